// File: rtl/spram_ctrl_pkg.sv
// Shared types and helpers for the iCE40UP SPRAM sequencer.
package spram_ctrl_pkg;

   localparam int SPRAM_AW     = 14;
   localparam int SPRAM_DW     = 16;
   localparam int SPRAM_MASK_W = 4;

   typedef enum logic [2:0] {
      PWR_ACTIVE  = 3'd0,
      PWR_STANDBY = 3'd1,
      PWR_SLEEP   = 3'd2,
      PWR_WAKE    = 3'd3,
      PWR_OFF     = 3'd4
   } pwr_state_e;

   // The macro masks nibbles; each byte enable covers two of them.
   function automatic logic [SPRAM_MASK_W-1:0] be_to_mask(input logic [1:0] be);
      return {be[1], be[1], be[0], be[0]};
   endfunction

endpackage

// File: rtl/spram_pwr_fsm.sv
// Idle-driven power sequencer for the SPRAM macro (STANDBY/SLEEP/WAKE).
// SPRAM_CTRL_POWEROFF_EN adds the OFF state and the pwroff_req handshake.
//
// state   | meaning
// ACTIVE  | macro accessible, idle timer running while nothing is issued
// STANDBY | ram_standby=1, any request returns to ACTIVE in one cycle
// SLEEP   | ram_standby=1 and ram_sleep=1, request starts WAKE
// WAKE    | ram_sleep released, wait for macro recovery before ACTIVE
// OFF     | macro power removed, requests ignored until pwroff_req drops
module spram_pwr_fsm
   import spram_ctrl_pkg::*;
#(
   parameter int STBY_IDLE_CYCLES  = 16,
   parameter int SLEEP_IDLE_CYCLES = 256,
   parameter int WAKE_CYCLES       = 4,
   parameter int CNT_W             = 10
) (
   input  logic       clk,
   input  logic       resetn,
   input  logic       req_valid,
   input  logic       accept,
   input  logic       busy,
`ifdef SPRAM_CTRL_POWEROFF_EN
   input  logic       pwroff_req,
   output logic       pwroff_active,
`endif
   output logic       accessible,
   output logic       ram_standby,
   output logic       ram_sleep,
   output logic       ram_poweroff,
   output logic [1:0] pwr_state
);

   localparam logic [CNT_W-1:0] STBY_LOAD  = CNT_W'(STBY_IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLEEP_LOAD = CNT_W'(SLEEP_IDLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] WAKE_LOAD  = CNT_W'(WAKE_CYCLES - 1);

   pwr_state_e       state_q, state_d;
   logic [CNT_W-1:0] idle_q, idle_d;
   logic [CNT_W-1:0] wake_q, wake_d;
   logic             accessible_q, accessible_d;
   logic             standby_q, standby_d;
   logic             sleep_q, sleep_d;

   // Timers count down; a value of LOAD corresponds to zero elapsed cycles.
   always_comb begin
      state_d = state_q;
      idle_d  = idle_q;
      wake_d  = wake_q;
      case (state_q)
         PWR_ACTIVE: begin
            if (accept || busy) begin
               idle_d = STBY_LOAD;
            end else if (idle_q == '0) begin
               state_d = PWR_STANDBY;
               idle_d  = SLEEP_LOAD;
            end else begin
               idle_d = idle_q - 1'b1;
            end
         end
         PWR_STANDBY: begin
            if (req_valid) begin
               state_d = PWR_ACTIVE;
               idle_d  = STBY_LOAD;
            end else if (idle_q == '0) begin
               state_d = PWR_SLEEP;
            end else begin
               idle_d = idle_q - 1'b1;
            end
         end
         PWR_SLEEP: begin
`ifdef SPRAM_CTRL_POWEROFF_EN
            if (pwroff_req) begin
               state_d = PWR_OFF;
            end else
`endif
            if (req_valid) begin
               state_d = PWR_WAKE;
               wake_d  = WAKE_LOAD;
            end
         end
         PWR_WAKE: begin
            if (wake_q == '0) begin
               state_d = PWR_ACTIVE;
               idle_d  = STBY_LOAD;
            end else begin
               wake_d = wake_q - 1'b1;
            end
         end
`ifdef SPRAM_CTRL_POWEROFF_EN
         PWR_OFF: begin
            if (!pwroff_req) begin
               state_d = PWR_WAKE;
               wake_d  = CNT_W'(2 * WAKE_CYCLES - 1);
            end
         end
`endif
         default: state_d = PWR_ACTIVE;
      endcase

      accessible_d = (state_d == PWR_ACTIVE);
      standby_d    = (state_d != PWR_ACTIVE);
      sleep_d      = (state_d == PWR_SLEEP) || (state_d == PWR_OFF);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q      <= PWR_ACTIVE;
         idle_q       <= STBY_LOAD;
         wake_q       <= '0;
         accessible_q <= 1'b0;
         standby_q    <= 1'b0;
         sleep_q      <= 1'b0;
      end else begin
         state_q      <= state_d;
         idle_q       <= idle_d;
         wake_q       <= wake_d;
         accessible_q <= accessible_d;
         standby_q    <= standby_d;
         sleep_q      <= sleep_d;
      end
   end

`ifdef SPRAM_CTRL_POWEROFF_EN
   logic poweroff_q, poweroff_d;

   assign poweroff_d = (state_d != PWR_OFF);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         poweroff_q <= 1'b1;
      end else begin
         poweroff_q <= poweroff_d;
      end
   end

   assign ram_poweroff  = poweroff_q;
   assign pwroff_active = (state_q == PWR_OFF);
`else
   assign ram_poweroff = 1'b1;
`endif

   always_comb begin
      case (state_q)
         PWR_ACTIVE:  pwr_state = 2'd0;
         PWR_STANDBY: pwr_state = 2'd1;
         PWR_SLEEP:   pwr_state = 2'd2;
         PWR_WAKE:    pwr_state = 2'd3;
         default:     pwr_state = 2'd2;
      endcase
   end

   assign accessible  = accessible_q;
   assign ram_standby = standby_q;
   assign ram_sleep   = sleep_q;

endmodule

// File: rtl/spram_ctrl.sv
// Request sequencer in front of one iCE40UP 16Kx16 SPRAM with idle power management.
// Defining SPRAM_CTRL_POWEROFF_EN adds pwroff_req/pwroff_active and the OFF state.
module spram_ctrl
   import spram_ctrl_pkg::*;
#(
   parameter int STBY_IDLE_CYCLES  = 16,
   parameter int SLEEP_IDLE_CYCLES = 256,
   parameter int WAKE_CYCLES       = 4,
   parameter int CNT_W             = 10
) (
   input  logic                    clk,
   input  logic                    resetn,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [SPRAM_AW-1:0]     req_addr,
   input  logic [SPRAM_DW-1:0]     req_wdata,
   input  logic [1:0]              req_be,
   output logic                    rsp_valid,
   output logic [SPRAM_DW-1:0]     rsp_data,
   output logic [SPRAM_AW-1:0]     ram_address,
   output logic [SPRAM_DW-1:0]     ram_datain,
   output logic [SPRAM_MASK_W-1:0] ram_maskwren,
   output logic                    ram_wren,
   output logic                    ram_chipselect,
   output logic                    ram_standby,
   output logic                    ram_sleep,
   output logic                    ram_poweroff,
   input  logic [SPRAM_DW-1:0]     ram_dataout,
`ifdef SPRAM_CTRL_POWEROFF_EN
   input  logic                    pwroff_req,
   output logic                    pwroff_active,
`endif
   output logic [1:0]              pwr_state
);

   logic                    accept;
   logic                    accessible;
   logic                    cs_q, cs_d;
   logic                    wren_q, wren_d;
   logic [SPRAM_AW-1:0]     addr_q, addr_d;
   logic [SPRAM_DW-1:0]     datain_q, datain_d;
   logic [SPRAM_MASK_W-1:0] mask_q, mask_d;
   logic                    rd_pend_q, rd_pend_d;
   logic                    rsp_valid_q, rsp_valid_d;
   logic [SPRAM_DW-1:0]     rsp_hold_q, rsp_hold_d;

   assign accept = req_valid && accessible;

   always_comb begin
      cs_d        = accept;
      wren_d      = accept && req_write;
      addr_d      = addr_q;
      datain_d    = datain_q;
      mask_d      = '0;
      rd_pend_d   = accept && !req_write;
      rsp_valid_d = rd_pend_q;
      rsp_hold_d  = rsp_hold_q;
      if (accept) begin
         addr_d   = req_addr;
         datain_d = req_wdata;
         mask_d   = be_to_mask(req_be);
      end
      if (rsp_valid_q) begin
         rsp_hold_d = ram_dataout;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cs_q        <= 1'b0;
         wren_q      <= 1'b0;
         addr_q      <= '0;
         datain_q    <= '0;
         mask_q      <= '0;
         rd_pend_q   <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_hold_q  <= '0;
      end else begin
         cs_q        <= cs_d;
         wren_q      <= wren_d;
         addr_q      <= addr_d;
         datain_q    <= datain_d;
         mask_q      <= mask_d;
         rd_pend_q   <= rd_pend_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_hold_q  <= rsp_hold_d;
      end
   end

   // DATAOUT is only valid the cycle after the macro read; capture it then and hold.
   assign rsp_data       = rsp_valid_q ? ram_dataout : rsp_hold_q;
   assign rsp_valid      = rsp_valid_q;
   assign req_ready      = accessible;
   assign ram_chipselect = cs_q;
   assign ram_wren       = wren_q;
   assign ram_address    = addr_q;
   assign ram_datain     = datain_q;
   assign ram_maskwren   = mask_q;

   spram_pwr_fsm #(
      .STBY_IDLE_CYCLES  (STBY_IDLE_CYCLES),
      .SLEEP_IDLE_CYCLES (SLEEP_IDLE_CYCLES),
      .WAKE_CYCLES       (WAKE_CYCLES),
      .CNT_W             (CNT_W)
   ) u_pwr_fsm (
      .clk           (clk),
      .resetn        (resetn),
      .req_valid     (req_valid),
      .accept        (accept),
      .busy          (cs_q),
`ifdef SPRAM_CTRL_POWEROFF_EN
      .pwroff_req    (pwroff_req),
      .pwroff_active (pwroff_active),
`endif
      .accessible    (accessible),
      .ram_standby   (ram_standby),
      .ram_sleep     (ram_sleep),
      .ram_poweroff  (ram_poweroff),
      .pwr_state     (pwr_state)
   );

endmodule

// File: tb/tb_spram_ctrl.sv
// Self-checking bench for spram_ctrl with a behavioural SPRAM macro and a read scoreboard.
module tb_spram_ctrl;

   logic        clk;
   logic        resetn;
   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic [13:0] req_addr;
   logic [15:0] req_wdata;
   logic [1:0]  req_be;
   logic        rsp_valid;
   logic [15:0] rsp_data;
   logic [13:0] ram_address;
   logic [15:0] ram_datain;
   logic [3:0]  ram_maskwren;
   logic        ram_wren;
   logic        ram_chipselect;
   logic        ram_standby;
   logic        ram_sleep;
   logic        ram_poweroff;
   logic [15:0] ram_dataout;
   logic [1:0]  pwr_state;

   spram_ctrl dut (
      .clk            (clk),
      .resetn         (resetn),
      .req_valid      (req_valid),
      .req_ready      (req_ready),
      .req_write      (req_write),
      .req_addr       (req_addr),
      .req_wdata      (req_wdata),
      .req_be         (req_be),
      .rsp_valid      (rsp_valid),
      .rsp_data       (rsp_data),
      .ram_address    (ram_address),
      .ram_datain     (ram_datain),
      .ram_maskwren   (ram_maskwren),
      .ram_wren       (ram_wren),
      .ram_chipselect (ram_chipselect),
      .ram_standby    (ram_standby),
      .ram_sleep      (ram_sleep),
      .ram_poweroff   (ram_poweroff),
      .ram_dataout    (ram_dataout),
      .pwr_state      (pwr_state)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   int rsp_seen = 0;

   always @(posedge clk) cyc <= cyc + 1;

   // behavioural macro
   logic [15:0] mem [0:16383];
   logic [15:0] ref_mem [0:16383];

   always @(posedge clk) begin
      if (ram_chipselect && ram_poweroff) begin
         if (ram_wren) begin
            for (int n = 0; n < 4; n++)
               if (ram_maskwren[n]) mem[ram_address][4*n +: 4] <= ram_datain[4*n +: 4];
         end else begin
            ram_dataout <= mem[ram_address];
         end
      end
   end

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   function automatic logic [3:0] mask_of(input logic [1:0] be);
      return {be[1], be[1], be[0], be[0]};
   endfunction

   // macro-port and response monitor
   logic        acc_prev = 1'b0;
   logic        op_w;
   logic [13:0] op_a;
   logic [15:0] op_d;
   logic [3:0]  op_m;

   always @(negedge clk) begin
      if (!resetn) begin
         acc_prev = 1'b0;
      end else begin
         if (acc_prev || ram_chipselect) begin
            total++;
            if (ram_chipselect !== acc_prev || ram_standby !== 1'b0 || ram_sleep !== 1'b0 ||
                (acc_prev && (ram_wren !== op_w || ram_address !== op_a ||
                              ram_datain !== op_d || ram_maskwren !== op_m))) begin
               bad++;
               $display("FAIL ram_port t=%0t: cs=%b we=%b a=%h d=%h m=%b stby=%b slp=%b, expected cs=%b we=%b a=%h d=%h m=%b stby=0 slp=0",
                        $time, ram_chipselect, ram_wren, ram_address, ram_datain, ram_maskwren,
                        ram_standby, ram_sleep, acc_prev, op_w, op_a, op_d, op_m);
            end
         end
         if (rsp_valid) begin
            total++;
            rsp_seen++;
            if (sb.size() == 0) begin
               bad++;
               $display("FAIL rsp_unexpected t=%0t: rsp_valid=1 data=%h, expected no response", $time, rsp_data);
            end else begin
               exp_t e;
               e = sb.pop_front();
               if (rsp_data !== e.data || cyc !== e.cyc) begin
                  bad++;
                  $display("FAIL rsp_data t=%0t: data=%h cycle=%0d, expected data=%h cycle=%0d",
                           $time, rsp_data, cyc, e.data, e.cyc);
               end
            end
         end
         acc_prev = req_valid && req_ready;
         op_w = req_write;
         op_a = req_addr;
         op_d = req_wdata;
         op_m = mask_of(req_be);
      end
   end

   task automatic step(input int n);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Called at drive time of a cycle whose upcoming edge accepts the request.
   task automatic sb_accept(input logic w, input logic [13:0] a, input logic [15:0] d, input logic [1:0] be);
      exp_t e;
      logic [3:0] m;
      m = mask_of(be);
      if (w) begin
         for (int n = 0; n < 4; n++)
            if (m[n]) ref_mem[a][4*n +: 4] = d[4*n +: 4];
      end else begin
         e.data = ref_mem[a];
         e.cyc  = cyc + 2;
         sb.push_back(e);
      end
   endtask

   // Holds the request until accepted; returns in the cycle after the accept.
   task automatic issue(input logic w, input logic [13:0] a, input logic [15:0] d,
                        input logic [1:0] be, output int waited);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      waited    = 0;
      while (req_ready !== 1'b1 && waited < 50) begin
         step(1);
         waited++;
      end
      if (req_ready !== 1'b1) begin
         total++;
         bad++;
         $display("FAIL issue_timeout: req_ready=%b after %0d cycles, expected 1", req_ready, waited);
      end else begin
         sb_accept(w, a, d, be);
         step(1);
      end
      req_valid = 1'b0;
   endtask

   task automatic test_reset;
      resetn    = 1'b0;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr  = '0;
      req_wdata = '0;
      req_be    = '0;
      for (int i = 0; i < 16384; i++) begin
         mem[i]     = '0;
         ref_mem[i] = '0;
      end
      #12;
      total++;
      if ({req_ready, rsp_valid, ram_chipselect, ram_wren, ram_standby, ram_sleep, ram_poweroff} !== 7'b0000001) begin
         bad++;
         $display("FAIL reset_ctrl: rdy=%b rv=%b cs=%b we=%b stby=%b slp=%b poff=%b, expected 0 0 0 0 0 0 1",
                  req_ready, rsp_valid, ram_chipselect, ram_wren, ram_standby, ram_sleep, ram_poweroff);
      end
      total++;
      if ({ram_address, ram_datain, ram_maskwren, pwr_state, rsp_data} !== 52'd0) begin
         bad++;
         $display("FAIL reset_data: a=%h d=%h m=%b pwr=%0d rsp=%h, expected all 0",
                  ram_address, ram_datain, ram_maskwren, pwr_state, rsp_data);
      end
      #10 resetn = 1'b1;
      #1;
      total++;
      if (req_ready !== 1'b0) begin
         bad++;
         $display("FAIL ready_before_edge: req_ready=%b, expected 0", req_ready);
      end
      step(1);
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL ready_after_edge: req_ready=%b, expected 1", req_ready);
      end
   endtask

   task automatic test_write_read;
      int w;
      issue(1'b1, 14'h0012, 16'hA5C3, 2'b11, w);
      issue(1'b0, 14'h0012, 16'h0000, 2'b11, w);
      step(4);
      total++;
      if (rsp_data !== 16'hA5C3) begin
         bad++;
         $display("FAIL rsp_hold: rsp_data=%h, expected a5c3", rsp_data);
      end
   endtask

   task automatic test_byte_mask;
      int w;
      issue(1'b1, 14'h0020, 16'h00FF, 2'b11, w);
      issue(1'b1, 14'h0020, 16'h1200, 2'b10, w);
      issue(1'b0, 14'h0020, 16'h0000, 2'b01, w);
      step(2);
      total++;
      if (rsp_data !== 16'h12FF) begin
         bad++;
         $display("FAIL byte_mask: rsp_data=%h, expected 12ff", rsp_data);
      end
   endtask

   task automatic test_standby;
      int w;
      issue(1'b1, 14'h0030, 16'h5A5A, 2'b11, w);
      step(16);
      total++;
      if (ram_standby !== 1'b0 || pwr_state !== 2'd0) begin
         bad++;
         $display("FAIL standby_early: stby=%b pwr=%0d, expected 0 0", ram_standby, pwr_state);
      end
      step(1);
      total++;
      if (ram_standby !== 1'b1 || ram_sleep !== 1'b0 || pwr_state !== 2'd1 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL standby_entry: stby=%b slp=%b pwr=%0d rdy=%b, expected 1 0 1 0",
                  ram_standby, ram_sleep, pwr_state, req_ready);
      end
      issue(1'b0, 14'h0030, 16'h0000, 2'b11, w);
      total++;
      if (w !== 1) begin
         bad++;
         $display("FAIL standby_wake_penalty: waited=%0d, expected 1", w);
      end
   endtask

   task automatic test_sleep;
      int w;
      issue(1'b1, 14'h0100, 16'hBEEF, 2'b11, w);
      step(272);
      total++;
      if (ram_sleep !== 1'b0 || ram_standby !== 1'b1 || pwr_state !== 2'd1) begin
         bad++;
         $display("FAIL sleep_early: slp=%b stby=%b pwr=%0d, expected 0 1 1", ram_sleep, ram_standby, pwr_state);
      end
      step(1);
      total++;
      if (ram_sleep !== 1'b1 || ram_standby !== 1'b1 || pwr_state !== 2'd2) begin
         bad++;
         $display("FAIL sleep_entry: slp=%b stby=%b pwr=%0d, expected 1 1 2", ram_sleep, ram_standby, pwr_state);
      end
      req_valid = 1'b1;
      req_write = 1'b0;
      req_addr  = 14'h0100;
      step(1);
      total++;
      if (pwr_state !== 2'd3 || ram_sleep !== 1'b0 || ram_standby !== 1'b1 || req_ready !== 1'b0) begin
         bad++;
         $display("FAIL wake_entry: pwr=%0d slp=%b stby=%b rdy=%b, expected 3 0 1 0",
                  pwr_state, ram_sleep, ram_standby, req_ready);
      end
      issue(1'b0, 14'h0100, 16'h0000, 2'b00, w);
      total++;
      if (w !== 4) begin
         bad++;
         $display("FAIL wake_length: waited=%0d more cycles, expected 4", w);
      end
      step(2);
      total++;
      if (rsp_data !== 16'hBEEF) begin
         bad++;
         $display("FAIL sleep_retention: rsp_data=%h, expected beef", rsp_data);
      end
   endtask

   task automatic test_threshold;
      int w;
      issue(1'b0, 14'h0012, 16'h0000, 2'b11, w);
      step(16);
      issue(1'b1, 14'h0040, 16'hC0DE, 2'b11, w);
      total++;
      if (w !== 0 || ram_standby !== 1'b0 || pwr_state !== 2'd0) begin
         bad++;
         $display("FAIL threshold_accept: waited=%0d stby=%b pwr=%0d, expected 0 0 0", w, ram_standby, pwr_state);
      end
      step(1);
      total++;
      if (ram_standby !== 1'b0 || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL threshold_no_standby: stby=%b rdy=%b, expected 0 1", ram_standby, req_ready);
      end
   endtask

   task automatic b2b_op(input logic w, input logic [13:0] a, input logic [15:0] d, input logic [1:0] be);
      req_valid = 1'b1;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      total++;
      if (req_ready !== 1'b1) begin
         bad++;
         $display("FAIL b2b_ready: req_ready=%b, expected 1", req_ready);
      end else begin
         sb_accept(w, a, d, be);
      end
      step(1);
   endtask

   task automatic test_back_to_back;
      int start;
      for (int i = 0; i < 8; i++)
         b2b_op(1'b1, 14'(14'h0200 + i), 16'($urandom), 2'($urandom_range(0, 3)));
      start = rsp_seen;
      for (int i = 0; i < 100; i++)
         b2b_op(1'b0, 14'(14'h0200 + (i % 10)), 16'h0000, 2'b11);
      req_valid = 1'b0;
      step(4);
      total++;
      if (rsp_seen - start !== 100) begin
         bad++;
         $display("FAIL b2b_count: responses=%0d, expected 100", rsp_seen - start);
      end
      total++;
      if (sb.size() !== 0) begin
         bad++;
         $display("FAIL sb_drain: pending=%0d, expected 0", sb.size());
      end
   endtask

   task automatic test_reset_mid;
      int w;
      int seen;
      issue(1'b0, 14'h0012, 16'h0000, 2'b11, w);
      seen = rsp_seen;
      resetn = 1'b0;
      #1;
      total++;
      if ({ram_chipselect, ram_wren, ram_standby, ram_sleep, ram_poweroff, req_ready, rsp_valid} !== 7'b0000100 ||
          {ram_address, ram_datain, ram_maskwren, pwr_state} !== 36'd0) begin
         bad++;
         $display("FAIL reset_mid: cs=%b we=%b stby=%b slp=%b poff=%b rdy=%b rv=%b a=%h d=%h m=%b pwr=%0d, expected 0 0 0 0 1 0 0 and zero buses",
                  ram_chipselect, ram_wren, ram_standby, ram_sleep, ram_poweroff, req_ready, rsp_valid,
                  ram_address, ram_datain, ram_maskwren, pwr_state);
      end
      sb.delete();
      step(2);
      resetn = 1'b1;
      step(4);
      total++;
      if (rsp_seen !== seen || req_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_drop: responses=%0d rdy=%b, expected %0d 1", rsp_seen, req_ready, seen);
      end
   endtask

   initial begin
      test_reset();
      test_write_read();
      test_byte_mask();
      test_standby();
      test_sleep();
      test_threshold();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
